// File: rtl/ps2_cmd_seq.sv
// PS/2 command sequencer: sends a command and an optional argument, runs the ACK/RESEND
// handshake with retries and a reply timeout, then gathers response bytes.
module ps2_cmd_seq #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRY      = 3,
    parameter int TMR_W          = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_byte0,
    input  logic [7:0]  cmd_byte1,
    input  logic        cmd_has_arg,
    input  logic [1:0]  cmd_resp_cnt,
    output logic        done,
    output logic [1:0]  status,
    output logic [23:0] resp_data,
    output logic [1:0]  resp_cnt,
    output logic [7:0]  stream_data,
    output logic        stream_valid,
    output logic        stream_error,
    input  logic [7:0]  rcv_data,
    input  logic        rcv_error,
    input  logic        rcv_strobe,
    input  logic        xmt_ready,
    output logic [7:0]  xmt_data,
    output logic        xmt_strobe
);

    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [7:0] BYTE_ACK    = 8'hFA;
    localparam logic [7:0] BYTE_RESEND = 8'hFE;
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_RESEND  = 2'b10;
    localparam logic [1:0] ST_RXERR   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_SEND0, S_ACK0, S_SEND1, S_ACK1, S_RESP, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        byte0_q, byte0_d;
    logic [7:0]        byte1_q, byte1_d;
    logic              has_arg_q, has_arg_d;
    logic [1:0]        exp_cnt_q, exp_cnt_d;
    logic [1:0]        status_q, status_d;
    logic [23:0]       resp_data_q, resp_data_d;
    logic [1:0]        resp_cnt_q, resp_cnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [7:0]        stream_data_q, stream_data_d;
    logic              stream_valid_q, stream_valid_d;
    logic              stream_error_q, stream_error_d;
    logic [TMR_W-1:0]  timer_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            byte0_q        <= '0;
            byte1_q        <= '0;
            has_arg_q      <= 1'b0;
            exp_cnt_q      <= '0;
            status_q       <= '0;
            resp_data_q    <= '0;
            resp_cnt_q     <= '0;
            timer_q        <= '0;
            retry_q        <= '0;
            stream_data_q  <= '0;
            stream_valid_q <= 1'b0;
            stream_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte0_q        <= byte0_d;
            byte1_q        <= byte1_d;
            has_arg_q      <= has_arg_d;
            exp_cnt_q      <= exp_cnt_d;
            status_q       <= status_d;
            resp_data_q    <= resp_data_d;
            resp_cnt_q     <= resp_cnt_d;
            timer_q        <= timer_d;
            retry_q        <= retry_d;
            stream_data_q  <= stream_data_d;
            stream_valid_q <= stream_valid_d;
            stream_error_q <= stream_error_d;
        end
    end

    assign timer_dec = (timer_q != '0) ? timer_q - TMR_ONE : '0;

    always_comb begin
        state_d        = state_q;
        byte0_d        = byte0_q;
        byte1_d        = byte1_q;
        has_arg_d      = has_arg_q;
        exp_cnt_d      = exp_cnt_q;
        status_d       = status_q;
        resp_data_d    = resp_data_q;
        resp_cnt_d     = resp_cnt_q;
        timer_d        = timer_q;
        retry_d        = retry_q;
        stream_data_d  = stream_data_q;
        stream_valid_d = 1'b0;
        stream_error_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Stream byte and command acceptance are independent and may coincide.
                if (rcv_strobe) begin
                    stream_data_d  = rcv_data;
                    stream_valid_d = ~rcv_error;
                    stream_error_d = rcv_error;
                end
                if (cmd_valid) begin
                    byte0_d     = cmd_byte0;
                    byte1_d     = cmd_byte1;
                    has_arg_d   = cmd_has_arg;
                    exp_cnt_d   = cmd_resp_cnt;
                    status_d    = ST_OK;
                    resp_data_d = '0;
                    resp_cnt_d  = '0;
                    retry_d     = '0;
                    state_d     = S_SEND0;
                end
            end
            S_SEND0, S_SEND1: begin
                if (xmt_ready) begin
                    timer_d = TMO_LOAD;
                    state_d = (state_q == S_SEND0) ? S_ACK0 : S_ACK1;
                end
            end
            S_ACK0, S_ACK1: begin
                timer_d = timer_dec;
                // A byte arriving in the final timer cycle takes priority over the timeout.
                if (rcv_strobe) begin
                    if (!rcv_error && rcv_data == BYTE_ACK) begin
                        retry_d = '0;
                        if (state_q == S_ACK0 && has_arg_q) begin
                            state_d = S_SEND1;
                        end else if (exp_cnt_q != 2'd0) begin
                            timer_d = TMO_LOAD;
                            state_d = S_RESP;
                        end else begin
                            status_d = ST_OK;
                            state_d  = S_DONE;
                        end
                    end else if (!rcv_error && rcv_data == BYTE_RESEND) begin
                        if (retry_q < RTY_MAX) begin
                            retry_d = retry_q + RTY_W'(1);
                            state_d = (state_q == S_ACK0) ? S_SEND0 : S_SEND1;
                        end else begin
                            status_d = ST_RESEND;
                            state_d  = S_DONE;
                        end
                    end else begin
                        status_d = ST_RXERR;
                        state_d  = S_DONE;
                    end
                end else if (timer_q <= TMR_ONE) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_DONE;
                end
            end
            S_RESP: begin
                timer_d = timer_dec;
                if (rcv_strobe) begin
                    if (rcv_error) begin
                        status_d = ST_RXERR;
                        state_d  = S_DONE;
                    end else begin
                        case (resp_cnt_q)
                            2'd0:    resp_data_d[7:0]   = rcv_data;
                            2'd1:    resp_data_d[15:8]  = rcv_data;
                            2'd2:    resp_data_d[23:16] = rcv_data;
                            default: ;
                        endcase
                        resp_cnt_d = resp_cnt_q + 2'd1;
                        timer_d    = TMO_LOAD;
                        if (resp_cnt_q + 2'd1 == exp_cnt_q) begin
                            status_d = ST_OK;
                            state_d  = S_DONE;
                        end
                    end
                end else if (timer_q <= TMR_ONE) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready  = 1'b0;
        done       = 1'b0;
        xmt_strobe = 1'b0;
        xmt_data   = 8'h00;
        case (state_q)
            S_IDLE:  cmd_ready = 1'b1;
            S_SEND0: begin
                xmt_data   = byte0_q;
                xmt_strobe = xmt_ready;
            end
            S_SEND1: begin
                xmt_data   = byte1_q;
                xmt_strobe = xmt_ready;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign status       = status_q;
    assign resp_data    = resp_data_q;
    assign resp_cnt     = resp_cnt_q;
    assign stream_data  = stream_data_q;
    assign stream_valid = stream_valid_q;
    assign stream_error = stream_error_q;

endmodule

// File: doc/ps2_cmd_seq.md
Name: ps2_cmd_seq

Overview:
- Command sequencer between a CPU-side register interface and the PS/2 host's receive/transmit byte interface.
- Sends a one- or two-byte device command (command plus optional argument).
- Enforces the ACK (0xFA) / RESEND (0xFE) handshake per byte with bounded retries and a reply timeout, then collects up to 3 response bytes.
- While no command is active, forwards unsolicited received bytes (scancodes, mouse packets) as a stream.

Parameters:
TIMEOUT_CYCLES, 1000000, reply timeout in clk cycles (20 ms at 50 MHz); valid range 1..2^TMR_W-1
MAX_RETRY, 3, retransmissions allowed per byte after 0xFE (total sends per byte = 1+MAX_RETRY)
TMR_W, 20, timer width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high in IDLE; command accepted when cmd_valid & cmd_ready
cmd_byte0  in  8  command byte
cmd_byte1  in  8  argument byte
cmd_has_arg  in  1  send cmd_byte1 after cmd_byte0 is ACKed
cmd_resp_cnt  in  2  response bytes expected after the final ACK (0..3)
done  out  1  one-cycle pulse, command finished
status  out  2  00 ok, 01 timeout, 10 resend exhausted, 11 receive error / unexpected byte
resp_data  out  24  responses; first byte in [7:0], then [15:8], then [23:16]
resp_cnt  out  2  response bytes captured
stream_data  out  8  unsolicited byte
stream_valid  out  1  one-cycle pulse, good unsolicited byte
stream_error  out  1  one-cycle pulse, unsolicited byte with rcv_error
rcv_data  in  8  from host
rcv_error  in  1  from host
rcv_strobe  in  1  from host, one-cycle
xmt_ready  in  1  from host
xmt_data  out  8  to host
xmt_strobe  out  1  to host

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0 except cmd_ready=1; timer, retry and response counters cleared.
- Reset mid-transfer aborts with no done pulse. The host is reset separately.
- Accepting a command:
  - latches byte0, byte1, has_arg and resp_cnt;
  - clears status, resp_data and resp_cnt to 0;
  - clears the retry counter;
  - goes to SEND0.
- status, resp_data and resp_cnt hold their values from the done cycle until the next accept.
- SEND0/SEND1:
  - xmt_data = latched byte0/byte1, held stable for the whole state.
  - xmt_strobe = 1 combinationally while in SENDx and xmt_ready=1, for exactly that one cycle.
  - In that cycle the timer loads TIMEOUT_CYCLES and the next state is ACK0/ACK1.
  - While xmt_ready=0, wait indefinitely; no timeout applies here.
- ACK0/ACK1:
  - Timer decrements each cycle.
  - rcv_strobe & ~rcv_error & data 0xFA: clear retries. ACK0 goes to SEND1 if has_arg, else RESP if resp_cnt≠0, else DONE(00). ACK1 goes to RESP if resp_cnt≠0, else DONE(00).
  - 0xFE: if retries < MAX_RETRY, retries+1 and return to the same SENDx; else DONE(10).
  - Any other byte, or rcv_error: DONE(11).
  - Timer reaches 0 without rcv_strobe: DONE(01).
  - rcv_strobe in the same cycle the timer hits 0: the byte wins.
- RESP:
  - Timer reloads on entry and after each byte.
  - Each good byte is written to slot resp_cnt and resp_cnt increments; at resp_cnt == latched count go to DONE(00).
  - rcv_error: DONE(11); bytes already captured are kept.
  - Timeout: DONE(01).
- DONE: done=1 for one cycle with status valid; next state IDLE.
- IDLE stream path:
  - rcv_strobe arriving in IDLE is registered: stream_data=rcv_data, and stream_valid (~rcv_error) or stream_error (rcv_error) pulses the next cycle.
  - If cmd_valid coincides with that rcv_strobe, both the stream byte and the command are accepted.
  - Bytes arriving outside IDLE are never streamed.
- Timer is TMR_W bits, decrements saturating at 0. Retry counter is wide enough for MAX_RETRY.

Test Plan:
- F4, no arg, resp 0; model returns FA 200 cycles after strobe -> one xmt_strobe with xmt_data=F4; done status 00, resp_cnt 0.
- ED with arg 02; model FA, FA -> strobes carry ED then 02, second only after first FA; done status 00.
- FF, resp 2; model FA, AA, 00 -> resp_data=0x0000AA, resp_cnt 2, status 00.
- MAX_RETRY=3:
  - replies FE, FE, FA -> 3 strobes of F4, status 00;
  - four FE -> 4 strobes, status 10.
- TIMEOUT_CYCLES=1000, no reply -> done exactly at strobe cycle + 1001, status 01; also:
  - reply 0x12 to a command -> status 11;
  - rcv_error during RESP -> status 11 with partial resp_cnt.
- Idle receives:
  - 1C good -> stream_valid pulse, stream_data=1C;
  - bad frame -> stream_error pulse;
  - cmd_valid in the same cycle as rcv_strobe -> both handled.
  - rst_n low during ACK0 -> cmd_ready=1, all other outputs 0, no done pulse.
